// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, register-bank, writeback and execute signals around the RV32I decode stage
interface decode_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [4:0]  rr0;
  logic [4:0]  rr1;
  logic [31:0] rs0;
  logic [31:0] rs1;
  logic        wb_regwrite;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs0;
  logic [31:0] ex_rs1;
  logic [31:0] ex_imm;
  logic [4:0]  ex_wr;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_alusrc;
  logic        ex_illegal;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [15:0] stall_count;

  modport master (
    output id_valid, id_instr, id_pc, rs0, rs1, wb_regwrite, wb_wr, wb_wd, flush, ex_ready,
    input  id_ready, rr0, rr1, ex_valid, ex_pc, ex_rs0, ex_rs1, ex_imm, ex_wr,
           ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr, ex_alusrc,
           ex_illegal, ex_funct3, ex_funct7b5, stall_count
  );

  modport slave (
    input  id_valid, id_instr, id_pc, rs0, rs1, wb_regwrite, wb_wr, wb_wd, flush, ex_ready,
    output id_ready, rr0, rr1, ex_valid, ex_pc, ex_rs0, ex_rs1, ex_imm, ex_wr,
           ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr, ex_alusrc,
           ex_illegal, ex_funct3, ex_funct7b5, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode with writeback bypass, load-use interlock and registered ID/EX entry
module decode_stage (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs0;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        alusrc;
    logic        illegal;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ex_entry_t;

  ex_entry_t   ex_q, ex_d, dec;
  logic        valid_q, valid_d;
  logic [15:0] stall_q, stall_d;
  logic        use0, use1, hold, hazard;
  logic [31:0] instr, op0, op1;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr   = bus.id_instr;
  assign bus.rr0 = instr[19:15];
  assign bus.rr1 = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Same-cycle writeback wins over the bank's stale read; x0 is hard-wired to zero.
  always_comb begin
    op0 = bus.rs0;
    op1 = bus.rs1;
    if (bus.wb_regwrite && bus.wb_wr != 5'd0 && bus.wb_wr == instr[19:15]) op0 = bus.wb_wd;
    if (bus.wb_regwrite && bus.wb_wr != 5'd0 && bus.wb_wr == instr[24:20]) op1 = bus.wb_wd;
    if (instr[19:15] == 5'd0) op0 = '0;
    if (instr[24:20] == 5'd0) op1 = '0;
  end

  always_comb begin
    dec          = '0;
    use0         = 1'b0;
    use1         = 1'b0;
    dec.pc       = bus.id_pc;
    dec.wr       = instr[11:7];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];
    dec.rs0      = op0;
    dec.rs1      = op1;
    case (instr[6:0])
      7'b0110011: begin dec.regwrite = 1'b1; use0 = 1'b1; use1 = 1'b1; end
      7'b0010011: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_i; use0 = 1'b1; end
      7'b0000011: begin
        dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_i; use0 = 1'b1;
      end
      7'b0100011: begin
        dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_s; use0 = 1'b1; use1 = 1'b1;
      end
      7'b1100011: begin dec.branch = 1'b1; dec.imm = imm_b; use0 = 1'b1; use1 = 1'b1; end
      7'b0110111: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_u; end
      7'b1101111: begin dec.regwrite = 1'b1; dec.jal = 1'b1; dec.imm = imm_j; end
      7'b1100111: begin
        dec.regwrite = 1'b1; dec.jalr = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_i; use0 = 1'b1;
      end
      default:    dec.illegal = 1'b1;
    endcase
    if (dec.wr == 5'd0) dec.regwrite = 1'b0;
  end

  assign hold   = valid_q && !bus.ex_ready;
  assign hazard = bus.id_valid && valid_q && ex_q.memread && ex_q.wr != 5'd0 &&
                  ((use0 && ex_q.wr == instr[19:15]) || (use1 && ex_q.wr == instr[24:20]));
  assign bus.id_ready = bus.flush || (!hold && !hazard);

  // Bubbles zero the whole entry so the execute-side controls are guaranteed inactive.
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    stall_d = stall_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ex_d    = '0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      ex_d    = '0;
      if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end else if (bus.id_valid) begin
      valid_d = 1'b1;
      ex_d    = dec;
    end else begin
      valid_d = 1'b0;
      ex_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs0      = ex_q.rs0;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_wr       = ex_q.wr;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_jal      = ex_q.jal;
  assign bus.ex_jalr     = ex_q.jalr;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_illegal  = ex_q.illegal;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7b5 = ex_q.funct7b5;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a table-driven reference model
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] pc, rs0, rs1, imm;
    logic [4:0]  wr;
    logic        regwrite, memread, memwrite, branch, jal, jalr, alusrc, illegal;
    logic [2:0]  f3;
    logic        f7;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid;
  ent_t m_ex;
  int   m_stall;
  logic m_after_reset;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit has(string s, byte c);
    for (int k = 0; k < s.len(); k++) if (s[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Opcode -> immediate format letter and control flags (w=regwrite a=alusrc l=load s=store b=branch j=jal r=jalr 0/1=operand use).
  function automatic void classify(logic [6:0] op, output byte fmt, output string fl);
    case (op)
      7'h33:   begin fmt = "R"; fl = "w01";  end
      7'h13:   begin fmt = "I"; fl = "wa0";  end
      7'h03:   begin fmt = "I"; fl = "wal0"; end
      7'h23:   begin fmt = "S"; fl = "as01"; end
      7'h63:   begin fmt = "B"; fl = "b01";  end
      7'h37:   begin fmt = "U"; fl = "wa";   end
      7'h6F:   begin fmt = "J"; fl = "wj";   end
      7'h67:   begin fmt = "I"; fl = "war0"; end
      default: begin fmt = "X"; fl = "";     end
    endcase
  endfunction

  function automatic ent_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
    ent_t  e;
    byte   fmt;
    string fl;
    logic [31:0] sgn;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    classify(ins[6:0], fmt, fl);
    e = '0;
    e.pc = pc; e.rs0 = a; e.rs1 = b; e.wr = ins[11:7]; e.f3 = ins[14:12]; e.f7 = ins[30];
    case (fmt)
      "I": e.imm = (sgn << 12) | 32'(ins[31:20]);
      "S": e.imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      "B": e.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      "U": e.imm = ins & 32'hFFFF_F000;
      "J": e.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: e.imm = 32'h0;
    endcase
    e.illegal  = (fmt == "X");
    e.regwrite = has(fl, "w") && (ins[11:7] != 0);
    e.alusrc   = has(fl, "a");
    e.memread  = has(fl, "l");
    e.memwrite = has(fl, "s");
    e.branch   = has(fl, "b");
    e.jal      = has(fl, "j");
    e.jalr     = has(fl, "r");
    return e;
  endfunction

  function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] bank);
    if (r == 0) return 32'h0;
    if (bus.wb_regwrite && bus.wb_wr == r) return bus.wb_wd;
    return bank;
  endfunction

  task automatic idle();
    bus.id_valid = 0; bus.id_instr = 0; bus.id_pc = 0; bus.rs0 = 0; bus.rs1 = 0;
    bus.wb_regwrite = 0; bus.wb_wr = 0; bus.wb_wd = 0; bus.flush = 0; bus.ex_ready = 1; reset = 0;
  endtask

  task automatic issue(logic [31:0] ins, logic [31:0] pc);
    bus.id_valid = 1; bus.id_instr = ins; bus.id_pc = pc;
    bus.rs0 = $urandom; bus.rs1 = $urandom;
  endtask

  task automatic check_ex();
    check("ex_valid", bus.ex_valid, m_valid);
    check("ex_regwrite", bus.ex_regwrite, m_valid & m_ex.regwrite);
    check("ex_memread", bus.ex_memread, m_valid & m_ex.memread);
    check("ex_memwrite", bus.ex_memwrite, m_valid & m_ex.memwrite);
    check("ex_branch", bus.ex_branch, m_valid & m_ex.branch);
    check("ex_jal", bus.ex_jal, m_valid & m_ex.jal);
    check("ex_jalr", bus.ex_jalr, m_valid & m_ex.jalr);
    check("stall_count", bus.stall_count, m_stall);
    if (m_valid || m_after_reset) begin
      check("ex_pc", bus.ex_pc, m_ex.pc);
      check("ex_rs0", bus.ex_rs0, m_ex.rs0);
      check("ex_rs1", bus.ex_rs1, m_ex.rs1);
      check("ex_imm", bus.ex_imm, m_ex.imm);
      check("ex_wr", bus.ex_wr, m_ex.wr);
      check("ex_alusrc", bus.ex_alusrc, m_ex.alusrc);
      check("ex_illegal", bus.ex_illegal, m_ex.illegal);
      if (!m_ex.illegal) begin
        check("ex_funct3", bus.ex_funct3, m_ex.f3);
        check("ex_funct7b5", bus.ex_funct7b5, m_ex.f7);
      end
    end
  endtask

  // Inputs are already driven; checks combinational outputs, advances one edge, checks ex_*.
  task automatic cycle();
    byte   fmt;
    string fl;
    logic  u0, u1, hold, haz;
    logic [4:0] a, b;
    ent_t  nx;
    #3;
    a = bus.id_instr[19:15];
    b = bus.id_instr[24:20];
    classify(bus.id_instr[6:0], fmt, fl);
    u0 = has(fl, "0");
    u1 = has(fl, "1");
    hold = m_valid && !bus.ex_ready;
    haz  = bus.id_valid && m_valid && m_ex.memread && m_ex.wr != 0 &&
           ((u0 && m_ex.wr == a) || (u1 && m_ex.wr == b));
    check("rr0", bus.rr0, a);
    check("rr1", bus.rr1, b);
    check("id_ready", bus.id_ready, bus.flush || (!hold && !haz));
    nx = ref_decode(bus.id_instr, bus.id_pc, operand(a, bus.rs0), operand(b, bus.rs1));
    @(posedge clk);
    #1;
    m_after_reset = 0;
    if (reset) begin
      m_valid = 0; m_ex = '0; m_stall = 0; m_after_reset = 1;
    end else if (bus.flush) begin
      m_valid = 0;
    end else if (hold) begin
      m_valid = m_valid;
    end else if (haz) begin
      m_valid = 0;
      if (m_stall < 65535) m_stall++;
    end else if (bus.id_valid) begin
      m_valid = 1; m_ex = nx;
    end else begin
      m_valid = 0;
    end
    check_ex();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67, 7'h7F};
    ins = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  int base;

  initial begin
    idle();
    reset = 1;
    m_valid = 0; m_ex = '0; m_stall = 0; m_after_reset = 1;
    @(posedge clk); #1;
    check_ex();
    cycle();

    // addi x5,x0,7
    idle(); issue(32'h0070_0293, 32'h100);
    cycle();
    check("addi_valid", bus.ex_valid, 1);
    check("addi_imm", bus.ex_imm, 7);
    check("addi_wr", bus.ex_wr, 5);
    check("addi_regwrite", bus.ex_regwrite, 1);
    check("addi_alusrc", bus.ex_alusrc, 1);

    // lw x6,0(x1) then add x7,x6,x2
    idle(); issue(32'h0000_A303, 32'h104); cycle();
    idle(); issue(32'h0023_03B3, 32'h108);
    #3 check("lu_id_ready", bus.id_ready, 0); #0;
    cycle();
    check("lu_bubble", bus.ex_valid, 0);
    check("lu_stall", bus.stall_count, 1);
    cycle();
    check("lu_issue", bus.ex_valid, 1);
    check("lu_issue_pc", bus.ex_pc, 32'h108);

    // writeback bypass into operand 0 (addi x1,x3,0)
    idle(); issue(32'h0001_8093, 32'h10C);
    bus.rs0 = 32'h11; bus.wb_regwrite = 1; bus.wb_wr = 3; bus.wb_wd = 32'hABCD;
    cycle();
    check("bypass_on", bus.ex_rs0, 32'hABCD);
    bus.wb_wr = 0;
    cycle();
    check("bypass_off", bus.ex_rs0, 32'h11);

    // hold for three cycles, then flush
    idle(); issue(32'h0070_0293, 32'h110); cycle();
    base = m_stall;
    bus.ex_ready = 0; bus.id_instr = 32'h0001_8093; bus.id_pc = 32'h114;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_pc", bus.ex_pc, 32'h110);
      check("hold_id_ready", bus.id_ready, 0);
    end
    bus.flush = 1;
    cycle();
    check("flush_valid", bus.ex_valid, 0);
    check("flush_stall", bus.stall_count, base);

    // illegal opcode and beq with imm -4
    idle(); issue(32'h0000_007F, 32'h200); cycle();
    check("illegal", bus.ex_illegal, 1);
    check("illegal_regwrite", bus.ex_regwrite, 0);
    check("illegal_imm", bus.ex_imm, 0);
    idle(); issue(32'hFE00_0EE3, 32'h204); cycle();
    check("beq_imm", bus.ex_imm, 32'hFFFF_FFFC);
    check("beq_branch", bus.ex_branch, 1);

    // reset asserted on the hazard cycle
    idle(); issue(32'h0000_A303, 32'h300); cycle();
    idle(); issue(32'h0023_03B3, 32'h304); reset = 1;
    cycle();
    check("rst_valid", bus.ex_valid, 0);
    check("rst_stall", bus.stall_count, 0);
    check("rst_imm", bus.ex_imm, 0);
    check("rst_wr", bus.ex_wr, 0);
    reset = 0;

    for (int i = 0; i < 4000; i++) begin
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_instr    = rand_instr();
      bus.id_pc       = $urandom & 32'hFFFF_FFFC;
      bus.rs0         = $urandom;
      bus.rs1         = $urandom;
      bus.wb_regwrite = $urandom_range(0, 1);
      bus.wb_wr       = 5'($urandom_range(0, 3));
      bus.wb_wd       = $urandom;
      bus.flush       = ($urandom_range(0, 11) == 0);
      bus.ex_ready    = ($urandom_range(0, 3) != 0);
      reset           = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising edge of clk only.
REQ-003 id_valid  input  1  upstream (fetch) presents an instruction.
REQ-004 id_instr  input  32  RV32I instruction word.
REQ-005 id_pc  input  32  PC of id_instr.
REQ-006 id_ready  output  1  decode accepts id_instr this cycle.
REQ-007 rr0, rr1  output  5 each  register-bank read addresses; combinational, always id_instr[19:15] and id_instr[24:20].
REQ-008 rs0, rs1  input  32 each  register-bank read data for rr0/rr1, same cycle.
REQ-009 wb_regwrite, wb_wr[4:0], wb_wd[31:0]  input  writeback port also driving the register bank this cycle.
REQ-010 flush  input  1  branch/jump redirect; discard the current ID instruction and the ID/EX contents.
REQ-011 ex_ready  input  1  execute stage consumes the ID/EX entry.
REQ-012 ex_valid  output  1  ID/EX entry valid.
REQ-013 ex_pc, ex_rs0, ex_rs1, ex_imm  output  32 each  registered PC, operands and immediate.
REQ-014 ex_wr  output  5  destination register (id_instr[11:7]).
REQ-015 ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr, ex_alusrc, ex_illegal  output  1 each  registered controls.
REQ-016 ex_funct3 [2:0], ex_funct7b5 [0]  output  ALU/branch/memory qualifiers.
REQ-017 stall_count  output  16  saturating count of load-use bubbles.

Function
REQ-018 Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111, JALR 1100111; any other opcode is illegal.
REQ-019 Immediates (sign-extended from instr[31]): I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R and illegal give 0.
REQ-020 regwrite=1 for R, I-ALU, LOAD, LUI, JAL, JALR; forced 0 when wr==0 or illegal.
REQ-021 alusrc=1 for I-ALU, LOAD, STORE, LUI, JALR; memread=LOAD; memwrite=STORE; branch=BRANCH; jal/jalr per opcode; illegal clears all other controls.
REQ-022 Operand uses: use0 for all legal opcodes except LUI, JAL; use1 for R, STORE, BRANCH.
REQ-023 WB bypass: operand N = wb_wd when wb_regwrite && wb_wr!=0 && wb_wr==rrN, else rsN; register x0 always reads 0.
REQ-024 hold = ex_valid && !ex_ready.
REQ-025 hazard = ex_valid && ex_memread && ex_wr!=0 && ((use0 && ex_wr==rr0) || (use1 && ex_wr==rr1)), evaluated only when id_valid.
REQ-026 id_ready = !hold && !hazard, or 1 when flush.
REQ-027 Per-edge priority: reset > flush (ex_valid<=0; ID instruction dropped) > hold (all ex_* unchanged) > hazard (ex_valid<=0 bubble, stall_count+1) > id_valid (load all ex_*, ex_valid<=1) > else ex_valid<=0.
REQ-028 Latency: an accepted instruction appears on ex_* exactly one cycle later; throughput one per cycle without hazards.
REQ-029 When ex_valid is 0, the ex_* data fields are don't-care except ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal and ex_jalr, which shall be 0.
REQ-030 stall_count saturates at 16'hFFFF; hold cycles and flush cycles do not count.

Reset
REQ-031 On reset: ex_valid=0; every ex_* output is 0; stall_count=0.
REQ-032 Reset asserted mid-stall or mid-hold overrides all else; id_ready after reset follows REQ-026, with ex_valid=0.

Verification
REQ-033 addi x5,x0,7 (0x00700293), id_valid=1, ex_ready=1 -> next cycle ex_valid=1, ex_imm=7, ex_wr=5, ex_regwrite=1, ex_alusrc=1.
REQ-034 Load-use: lw x6,0(x1) accepted, then add x7,x6,x2 -> one bubble (ex_valid=0), id_ready=0 for one cycle, stall_count=1, add issues the following cycle.
REQ-035 Bypass: rr0=3, rs0=0x11, wb_regwrite=1, wb_wr=3, wb_wd=0xABCD -> ex_rs0=0xABCD; with wb_wr=0 -> ex_rs0=0x11.
REQ-036 Hold then flush: ex_ready=0 for 3 cycles -> ex_* stable and id_ready=0; flush -> ex_valid=0 next cycle, stall_count unchanged.
REQ-037 Opcode 0x0000007F -> ex_illegal=1, ex_regwrite=0, ex_imm=0; beq with imm -4 -> ex_imm=0xFFFFFFFC, ex_branch=1.
REQ-038 Reset asserted during a hazard bubble -> next cycle all ex_*=0 and stall_count=0.
